// File: rtl/toggle_event_receiver.sv
// Receive side of a toggle-signalled event link: synchronises the toggle line,
// decodes each level change into one event, and queues/counts the events.
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int DEPTH_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tog_in,
  input  logic               enable,
  input  logic               clr_count,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic               evt_pulse,
  output logic [DEPTH_W-1:0] pending,
  output logic [CNT_W-1:0]   evt_count,
  output logic               overflow
);

  localparam logic [DEPTH_W-1:0] PEND_MAX = '1;
  localparam logic [DEPTH_W-1:0] PEND_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   last_p1;
  logic                   toggle;
  logic                   evt;
  logic                   pop;
  logic                   pend_full;

  // Saturating pending update; a decrement is only requested when non-empty.
  function automatic logic [DEPTH_W-1:0] pend_next(
    input logic [DEPTH_W-1:0] cur,
    input logic               inc,
    input logic               dec
  );
    logic [DEPTH_W-1:0] res;
    res = cur;
    if (inc && !dec) begin
      res = (cur == PEND_MAX) ? cur : cur + PEND_ONE;
    end else if (!inc && dec) begin
      res = cur - PEND_ONE;
    end
    return res;
  endfunction

  // Stage p0: synchroniser chain on the asynchronous toggle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], tog_in};
    end
  end

  // Stage p1: last-level tracking runs even while disabled, so re-enable is silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p1 <= 1'b0;
    end else begin
      last_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign toggle    = sync_p0[SYNC_STAGES-1] ^ last_p1;
  assign evt       = toggle & enable;
  assign evt_valid = (pending != '0);
  assign pop       = evt_valid & evt_ready;
  assign pend_full = (pending == PEND_MAX);

  // Stage p2: registered event outputs; clr_count outranks a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_pulse <= 1'b0;
      pending   <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      evt_pulse <= evt;
      pending   <= pend_next(pending, evt, pop);
      if (clr_count) begin
        evt_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (evt) begin
          evt_count <= evt_count + CNT_ONE;
        end
        if (evt && !pop && pend_full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Scoreboard bench for toggle_event_receiver: a history-based reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_toggle_event_receiver;

  localparam int S       = 2;
  localparam int CNT_W   = 8;
  localparam int DEPTH_W = 3;
  localparam int PMAX    = (1 << DEPTH_W) - 1;

  logic               clk;
  logic               rst;
  logic               tog_in;
  logic               enable;
  logic               clr_count;
  logic               evt_ready;
  logic               evt_valid;
  logic               evt_pulse;
  logic [DEPTH_W-1:0] pending;
  logic [CNT_W-1:0]   evt_count;
  logic               overflow;

  typedef struct packed {
    logic               pulse;
    logic [DEPTH_W-1:0] pend;
    logic               valid;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: hist[i] is the tog_in level sampled i+1 edges ago
  bit hist[0:S];
  int m_pend = 0;
  int m_cnt  = 0;
  bit m_ovf  = 0;
  bit m_pulse = 0;

  toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(CNT_W), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .enable(enable),
    .clr_count(clr_count), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_pulse(evt_pulse), .pending(pending), .evt_count(evt_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the DUT state after the next rising edge from the inputs applied now
  task automatic model_edge(input bit r, input bit t, input bit e, input bit c, input bit y);
    bit   ev, pp;
    exp_t x;
    if (r) begin
      for (int i = 0; i <= S; i++) hist[i] = 1'b0;
      m_pend = 0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      ev = (hist[S-1] != hist[S]) && e;
      pp = (m_pend > 0) && y;
      if (ev && !pp) begin
        if (m_pend < PMAX) m_pend = m_pend + 1;
        else if (!c) m_ovf = 1;
      end else if (!ev && pp) begin
        m_pend = m_pend - 1;
      end
      if (c) begin
        m_cnt = 0; m_ovf = 0;
      end else if (ev) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      m_pulse = ev;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = t;
    end
    x.pulse = m_pulse;
    x.pend  = DEPTH_W'(m_pend);
    x.valid = (m_pend != 0);
    x.cnt   = CNT_W'(m_cnt);
    x.ovf   = m_ovf;
    exp_q.push_back(x);
  endtask

  task automatic step(input bit r, input bit t, input bit e, input bit c, input bit y);
    @(negedge clk);
    rst = r; tog_in = t; enable = e; clr_count = c; evt_ready = y;
    model_edge(r, t, e, c, y);
  endtask

  // Monitor: one expected record per rising edge, compared just after it
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        vectors++;
        if (evt_pulse !== x.pulse || pending !== x.pend || evt_valid !== x.valid ||
            evt_count !== x.cnt || overflow !== x.ovf) begin
          miscompares++;
          $display("FAIL outputs t=%0t got pulse=%b pend=%0d valid=%b cnt=%0d ovf=%b exp pulse=%b pend=%0d valid=%b cnt=%0d ovf=%b",
                   $time, evt_pulse, pending, evt_valid, evt_count, overflow,
                   x.pulse, x.pend, x.valid, x.cnt, x.ovf);
        end
      end
    end
  end

  initial begin
    bit t;
    rst = 1'b1; tog_in = 1'b0; enable = 1'b1; clr_count = 1'b0; evt_ready = 1'b0;

    // Reset with the line high, then release: one event expected
    repeat (3) step(1, 1, 1, 0, 0);
    t = 1;
    repeat (5) step(0, t, 1, 0, 0);
    step(0, t, 1, 0, 1);
    repeat (2) step(0, t, 1, 0, 0);

    // Single event held pending, then popped
    t = ~t;
    repeat (5) step(0, t, 1, 0, 0);
    step(0, t, 1, 0, 1);
    repeat (2) step(0, t, 1, 0, 0);

    // Saturate pending with 8 events, then clear count/overflow
    for (int i = 0; i < 8; i++) begin
      t = ~t;
      repeat (2) step(0, t, 1, 0, 0);
    end
    repeat (3) step(0, t, 1, 0, 0);
    step(0, t, 1, 1, 0);
    repeat (2) step(0, t, 1, 0, 0);

    // Event and pop on the same edge while full
    t = ~t;
    step(0, t, 1, 0, 0);
    step(0, t, 1, 0, 0);
    step(0, t, 1, 0, 1);
    repeat (2) step(0, t, 1, 0, 0);

    // Toggles absorbed while disabled, then one decoded toggle
    for (int i = 0; i < 3; i++) begin
      t = ~t;
      repeat (2) step(0, t, 0, 0, 0);
    end
    repeat (3) step(0, t, 0, 0, 0);
    repeat (3) step(0, t, 1, 0, 0);
    t = ~t;
    repeat (4) step(0, t, 1, 0, 0);

    // Synchronous toggling every cycle drives evt_count through its wrap
    for (int i = 0; i < 270; i++) begin
      t = ~t;
      step(0, t, 1, 0, 1'($urandom_range(0, 1)));
    end
    repeat (4) step(0, t, 1, 0, 0);

    // Reset one cycle after a toggle discards it
    t = ~t;
    step(0, t, 1, 0, 0);
    step(1, t, 1, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0);
    t = 0;
    repeat (5) step(0, t, 1, 0, 0);

    // Randomised traffic including occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) t = ~t;
      step(($urandom_range(0, 199) == 0), t, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
    end
    repeat (4) step(0, t, 1, 0, 1);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d left exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
